// File: rtl/serial_word_rx.sv
// serial_word_rx: serial-in, parallel-out word receiver.
// Assembles WIDTH-bit frames from a qualified bit stream (MSB- or LSB-first, chosen per frame)
// and presents each word on a single-slot valid/ready output with a sticky overrun flag.
// Optional feature: define SERIAL_WORD_RX_PARITY_EN to append one even-parity bit per frame
// and expose parity_err alongside out_data.
module serial_word_rx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             lsb_first,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
`ifdef SERIAL_WORD_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SERIAL_WORD_RX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic              lsb_q, lsb_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              busy_q;
  logic              overrun_q, overrun_d;
  logic              perr_q, perr_d;

  logic              commit;
  logic [WIDTH-1:0]  commit_word;
  logic              commit_perr;
  logic [WIDTH-1:0]  shifted;
  logic [WIDTH-1:0]  fresh;
  logic              slot_free;

  // Frame FSM: bit assembly, frame abort on start, and word commit into the output slot
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    lsb_d       = lsb_q;
    commit      = 1'b0;
    commit_word = sr_q;
    commit_perr = 1'b0;
    // Continue the current frame in its latched order
    shifted = lsb_q ? {sin, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sin};
    // First bit of a new frame uses the order sampled on this very bit
    fresh   = lsb_first ? {sin, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, sin};

    if (sin_valid) begin
      if (start) begin
        // Start in any state opens a new frame; a partial frame is silently dropped
        state_d = StShift;
        cnt_d   = CntW'(1);
        sr_d    = fresh;
        lsb_d   = lsb_first;
      end else begin
        case (state_q)
          StShift: begin
            sr_d = shifted;
            if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
              state_d = StPar;
              cnt_d   = CntW'(WIDTH);
`else
              commit      = 1'b1;
              commit_word = shifted;
              state_d     = StIdle;
              cnt_d       = '0;
`endif
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
`ifdef SERIAL_WORD_RX_PARITY_EN
          StPar: begin
            // Even parity over data plus parity bit must be zero
            commit      = 1'b1;
            commit_word = sr_q;
            commit_perr = (^sr_q) ^ sin;
            state_d     = StIdle;
            cnt_d       = '0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output slot: commit if free (including consume-and-refill), else flag overrun
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    perr_d      = perr_q;
    overrun_d   = overrun_q;
    slot_free   = !out_valid_q || out_ready;
    if (commit) begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_data_d  = commit_word;
        perr_d      = commit_perr;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      lsb_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      lsb_q       <= lsb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= (state_d != StIdle);
      overrun_q   <= overrun_d;
      perr_q      <= perr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  // Parity flag has no consumer without the parity option
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

- Serial-in, parallel-out word receiver: takes a qualified 1-bit stream, assembles WIDTH-bit words, delivers them over a valid/ready handshake.
- Bit order is selectable per frame: MSB-first, or LSB-first (the result equals the bit-reversed MSB-first word, so no separate reversal stage is needed downstream).
- Sits at the receive end of the bit-serial link into the datapath; the matching transmitter drives `start`/`sin_valid`/`sin`.

## Interface
Parameters:
- `WIDTH`, default 16: data bits per frame (at least 2).

Ports:
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  marks the first bit of a frame; only meaningful when `sin_valid`=1.
- `sin_valid`  input  1  `sin` holds a bit this cycle.
- `sin`  input  1  serial data bit.
- `lsb_first`  input  1  bit-order select; sampled on the frame's start bit only.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_valid`  output  1  `out_data` holds an unconsumed word.
- `out_data`  output  WIDTH  assembled word.
- `busy`  output  1  a frame is in progress (state is not IDLE).
- `overrun`  output  1  sticky: a completed word was dropped. Cleared only by `rst`.
- `parity_err`  output  1  present only with `SERIAL_WORD_RX_PARITY_EN`. Parity result for the word in `out_data`.

## Operation
Reset values: state IDLE; shift register, bit count, `out_data`, `out_valid`, `busy`, `overrun` and `parity_err` all 0.

State machine:
- **IDLE**
  - A bit cycle (`sin_valid`=1) with `start`=1: accept the bit, latch `lsb_first`, set count=1, go to SHIFT.
  - A bit cycle with `start`=0 is ignored.
- **SHIFT**
  - Each bit cycle accepts one bit and increments the count.
  - `start`=1 during a bit cycle aborts the partial frame. That bit becomes bit 1 of a new frame (count=1, `lsb_first` re-latched). No word is emitted and `overrun` is not set.
  - When the WIDTH-th bit is accepted:
    - without the macro, commit the word and go to IDLE;
    - with the macro, go to PAR.
- **PAR** (macro only)
  - The next bit cycle carries the parity bit: commit the word and the parity check, then go to IDLE.
  - If `start`=1 on that cycle, abort as in SHIFT.

Bit placement:
- MSB-first: shift register <= {sr[WIDTH-2:0], sin}. The first bit received ends up in bit WIDTH-1.
- LSB-first: shift register <= {sin, sr[WIDTH-1:1]}. The first bit received ends up in bit 0.

Commit:
- The output slot is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle (consume and refill).
- If the slot is free: `out_data` <= assembled word and `out_valid` <= 1.
- If the slot is not free: the new word is discarded, `overrun` <= 1, and `out_data` is unchanged.

Handshake:
- `out_valid`=1 and `out_ready`=1 with no commit in that cycle clears `out_valid`.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency: `out_valid` rises the cycle after the edge that accepts the final bit (the WIDTH-th bit, or the parity bit with the macro).
- Throughput: one bit per clock. Back-to-back frames need no idle cycle; a start bit is accepted in IDLE on the cycle right after commit.
- `sin_valid`=0 cycles stall the frame indefinitely; there is no timeout.
- `busy` is registered and mirrors state≠IDLE.
- `rst` mid-frame or mid-hold returns every output to its reset value immediately, independent of `clk`.

## Configuration
- `SERIAL_WORD_RX_PARITY_EN` defined:
  - each frame carries one extra bit after the WIDTH data bits;
  - even parity: XOR of the data bits and the parity bit must be 0;
  - `parity_err` <= 1 on a mismatch, registered together with `out_data`;
  - the word is still delivered on a mismatch;
  - `parity_err` follows the same commit/drop rules as `out_data`.
- Undefined: no PAR state, no `parity_err` port, and frames are exactly WIDTH bits.

## Test plan
- Reset, WIDTH=16, MSB-first: send bits of 0xA5C3 (first bit is bit 15), `out_ready`=1 → `out_valid` pulses for 1 cycle, `out_data`=0xA5C3, `busy` falls the same cycle.
- Same serial stream with `lsb_first`=1 on the start bit → `out_data`=0xC3A5 (bit-reverse of 0xA5C3).
- Two back-to-back frames (0x0001, 0x8000) with `out_ready`=0 throughout → first word 0x0001 held stable, second word dropped, `overrun`=1. Then raise `out_ready` → one handshake, `out_valid` clears, `overrun` stays 1.
- Assert `start` on bit 7 of a frame, then send 16 bits of 0x1234 → exactly one word 0x1234, `overrun`=0. Randomly deassert `sin_valid` for 1-3 cycles throughout → same result.
- Assert `rst` after 10 bits → all outputs 0, state IDLE. A fresh frame of 0xFFFF then completes correctly.
- With the macro: frame 0x0003 with parity bit 0 → `parity_err`=0. Same frame with parity bit 1 → `parity_err`=1 and `out_data`=0x0003.
